// File: rtl/gmii_tx_arbiter_pkg.sv
// Shared definitions for the two-source GMII transmit arbiter: FSM state
// encoding, default timing constants and the round-robin pick helper.
package gmii_tx_arbiter_pkg;

    // Width of one GMII data byte
    localparam int GMII_W = 8;

    // Default idle cycles between frames (96 bit times at 1 Gb/s)
    localparam int DEF_IFG_CYCLES = 12;

    // Default number of cycles a granted source may take to start its frame
    localparam int DEF_START_TO = 64;

    // Default longest frame in bytes, preamble and SFD included
    localparam int DEF_MAX_LEN = 1530;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_SEND  = 2'd2,
        ST_IFG   = 2'd3
    } arb_state_e;

    // Round-robin choice: a lone requester wins outright, and on a tie the
    // source that was not served last goes next
    function automatic logic pick_grant(input logic r0, input logic r1, input logic last);
        if (r0 && r1) begin
            return ~last;
        end else if (r1) begin
            return 1'b1;
        end else begin
            return 1'b0;
        end
    endfunction

endpackage

// File: rtl/gmii_tx_arbiter.sv
// Round-robin arbiter sharing one GMII transmit port between two frame
// sources. It forwards the granted byte stream through one register stage,
// enforces the inter-frame gap, revokes unused grants and truncates frames
// that run past MAX_LEN bytes.
module gmii_tx_arbiter
    import gmii_tx_arbiter_pkg::*;
#(
    parameter int IFG_CYCLES = DEF_IFG_CYCLES,
    parameter int START_TO   = DEF_START_TO,
    parameter int MAX_LEN    = DEF_MAX_LEN
) (
    input  logic              gmii_tx_clk,
    input  logic              sys_rst_n,
    input  logic              req0,
    input  logic              req1,
    output logic              ack0,
    output logic              ack1,
    input  logic              tx_en0,
    input  logic              tx_en1,
    input  logic [GMII_W-1:0] txd0,
    input  logic [GMII_W-1:0] txd1,
    output logic              gmii_tx_en,
    output logic [GMII_W-1:0] gmii_txd,
    output logic              frame_abort
);

    // Counter widths are sized so the largest value each one reaches fits
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int IFG_W = $clog2(IFG_CYCLES + 1);
    localparam int TO_W  = $clog2(START_TO + 1);

    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(START_TO - 1);

    arb_state_e        state_q, state_d;
    logic              sel_q, sel_d;
    logic              last_q, last_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [IFG_W-1:0]  ifg_q, ifg_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              gmii_tx_en_q, gmii_tx_en_d;
    logic [GMII_W-1:0] gmii_txd_q, gmii_txd_d;
    logic              frame_abort_q, frame_abort_d;

    logic              sel_en;
    logic [GMII_W-1:0] sel_txd;
    logic              port_owned;
    logic              start_timeout;
    logic              truncate;

    // Only the selected source is ever looked at; the other one is muted here
    assign sel_en  = sel_q ? tx_en1 : tx_en0;
    assign sel_txd = sel_q ? txd1 : txd0;

    assign port_owned    = (state_q == ST_GRANT) || (state_q == ST_SEND);
    assign start_timeout = (state_q == ST_GRANT) && !sel_en && (to_q == TO_LAST);
    assign truncate      = (state_q == ST_SEND) && sel_en && (len_q == LEN_MAX);

    // State, arbitration memory, counters and the output register stage
    always_ff @(posedge gmii_tx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= ST_IDLE;
            sel_q         <= 1'b0;
            last_q        <= 1'b1;
            len_q         <= '0;
            ifg_q         <= '0;
            to_q          <= '0;
            gmii_tx_en_q  <= 1'b0;
            gmii_txd_q    <= '0;
            frame_abort_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            last_q        <= last_d;
            len_q         <= len_d;
            ifg_q         <= ifg_d;
            to_q          <= to_d;
            gmii_tx_en_q  <= gmii_tx_en_d;
            gmii_txd_q    <= gmii_txd_d;
            frame_abort_q <= frame_abort_d;
        end
    end

    // Next-state logic; gap and timeout counters fall back to zero whenever
    // they are not counting, so each starts from zero on entry to its state
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        len_d   = len_q;
        ifg_d   = '0;
        to_d    = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    state_d = ST_GRANT;
                    sel_d   = pick_grant(req0, req1, last_q);
                    last_d  = pick_grant(req0, req1, last_q);
                end
            end
            ST_GRANT: begin
                if (sel_en) begin
                    state_d = ST_SEND;
                    len_d   = LEN_ONE;
                end else if (start_timeout) begin
                    state_d = ST_IFG;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            ST_SEND: begin
                if (!sel_en || truncate) begin
                    state_d = ST_IFG;
                end else begin
                    len_d = len_q + LEN_W'(1);
                end
            end
            ST_IFG: begin
                if (ifg_q == IFG_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    ifg_d = ifg_q + IFG_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode: grants follow the state, and the data path forwards the
    // selected byte only while the port is owned and no abort is happening
    always_comb begin
        ack0          = port_owned && !sel_q;
        ack1          = port_owned && sel_q;
        gmii_tx_en_d  = port_owned && sel_en && !truncate;
        gmii_txd_d    = gmii_tx_en_d ? sel_txd : '0;
        frame_abort_d = start_timeout || truncate;
    end

    assign gmii_tx_en  = gmii_tx_en_q;
    assign gmii_txd    = gmii_txd_q;
    assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Directed bench for gmii_tx_arbiter: a table of single-cycle vectors for a
// short frame and the gap that follows, then hand-written sequences for round
// robin, start timeout, truncation, source isolation and reset mid-frame.
module tb_gmii_tx_arbiter;
    import gmii_tx_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, txen0, txen1;
    logic [7:0] txd0, txd1;
    logic       ack0, ack1, gtx, abort;
    logic [7:0] gtxd;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       req0;
        logic       req1;
        logic       txen0;
        logic       txen1;
        logic [7:0] txd0;
        logic [7:0] txd1;
        logic       ack0;
        logic       ack1;
        logic       gtx;
        logic [7:0] gtxd;
        logic       abort;
    } vec_t;

    vec_t vecs[$];

    // 125 MHz transmit clock
    always #4 clk = ~clk;

    gmii_tx_arbiter #(
        .IFG_CYCLES(12),
        .START_TO(64),
        .MAX_LEN(1530)
    ) dut (
        .gmii_tx_clk(clk),
        .sys_rst_n(rst_n),
        .req0(req0),
        .req1(req1),
        .ack0(ack0),
        .ack1(ack1),
        .tx_en0(txen0),
        .tx_en1(txen1),
        .txd0(txd0),
        .txd1(txd1),
        .gmii_tx_en(gtx),
        .gmii_txd(gtxd),
        .frame_abort(abort)
    );

    function automatic vec_t mk(input logic r0, input logic r1, input logic e0, input logic e1,
                                input logic [7:0] d0, input logic [7:0] d1,
                                input logic a0, input logic a1, input logic g,
                                input logic [7:0] gd, input logic ab);
        vec_t v;
        v.req0 = r0;  v.req1 = r1;  v.txen0 = e0; v.txen1 = e1;
        v.txd0 = d0;  v.txd1 = d1;  v.ack0 = a0;  v.ack1 = a1;
        v.gtx = g;    v.gtxd = gd;  v.abort = ab;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        req0  = v.req0;
        req1  = v.req1;
        txen0 = v.txen0;
        txen1 = v.txen1;
        txd0  = v.txd0;
        txd1  = v.txd1;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic doReset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        req0 = 0; req1 = 0; txen0 = 0; txen1 = 0; txd0 = 0; txd1 = 0;
        tick();
        tick();
        checkOutput({tag, " reset ack0"}, 32'(ack0), 0);
        checkOutput({tag, " reset ack1"}, 32'(ack1), 0);
        checkOutput({tag, " reset gmii_tx_en"}, 32'(gtx), 0);
        checkOutput({tag, " reset gmii_txd"}, 32'(gtxd), 0);
        checkOutput({tag, " reset frame_abort"}, 32'(abort), 0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 0; req1 = 0; txen0 = 0; txen1 = 0; txd0 = 0; txd1 = 0;

        // Short frame from source 0, a request from 1 arriving mid-frame,
        // the 12-cycle gap with noise on tx_en, then a one-byte frame from 1
        vecs.push_back(mk(1,0, 0,0, 8'h00,8'h00, 1,0, 0,8'h00, 0));
        vecs.push_back(mk(1,0, 1,1, 8'hA1,8'hFF, 1,0, 1,8'hA1, 0));
        vecs.push_back(mk(1,1, 1,0, 8'hA2,8'h55, 1,0, 1,8'hA2, 0));
        vecs.push_back(mk(0,1, 0,1, 8'h77,8'h66, 0,0, 0,8'h00, 0));
        for (int i = 0; i < 11; i++)
            vecs.push_back(mk(0,1, 1,1, 8'h33,8'h44, 0,0, 0,8'h00, 0));
        vecs.push_back(mk(0,1, 0,0, 8'h00,8'h00, 0,0, 0,8'h00, 0));
        vecs.push_back(mk(0,1, 1,0, 8'h12,8'h00, 0,1, 0,8'h00, 0));
        vecs.push_back(mk(0,1, 1,1, 8'h99,8'hC3, 0,1, 1,8'hC3, 0));
        vecs.push_back(mk(0,0, 0,0, 8'h00,8'h00, 0,0, 0,8'h00, 0));

        doReset("table");
        foreach (vecs[k]) begin
            applyStimulus(vecs[k]);
            tick();
            checkOutput($sformatf("vec%0d ack0", k), 32'(ack0), 32'(vecs[k].ack0));
            checkOutput($sformatf("vec%0d ack1", k), 32'(ack1), 32'(vecs[k].ack1));
            checkOutput($sformatf("vec%0d gmii_tx_en", k), 32'(gtx), 32'(vecs[k].gtx));
            checkOutput($sformatf("vec%0d gmii_txd", k), 32'(gtxd), 32'(vecs[k].gtxd));
            checkOutput($sformatf("vec%0d frame_abort", k), 32'(abort), 32'(vecs[k].abort));
        end

        // Single 100-byte frame from source 0 while source 1 toggles randomly
        begin
            int zeroBad = 0;
            doReset("single");
            req0 = 1;
            tick();
            checkOutput("single ack0 rise", 32'(ack0), 1);
            for (int i = 0; i < 100; i++) begin
                txen0 = 1; txd0 = 8'(i);
                txen1 = 1'($urandom); txd1 = 8'($urandom);
                tick();
                checkOutput($sformatf("single byte%0d en", i), 32'(gtx), 1);
                checkOutput($sformatf("single byte%0d data", i), 32'(gtxd), 32'(i));
            end
            txen0 = 0; req0 = 0; txd0 = 8'hEE;
            tick();
            checkOutput("single ack0 fall", 32'(ack0), 0);
            checkOutput("single end gmii_tx_en", 32'(gtx), 0);
            for (int i = 0; i < 20; i++) begin
                txen1 = 1'($urandom); txd1 = 8'($urandom);
                txen0 = 1'($urandom); txd0 = 8'($urandom);
                tick();
                if (gtx !== 1'b0 || gtxd !== 8'h00) zeroBad++;
            end
            checkOutput("isolation quiet output", 32'(zeroBad), 0);
            txen0 = 0; txen1 = 0;
        end

        // Both sources always requesting, 64-byte frames each
        begin
            int grants[$];
            int sent0 = 0, sent1 = 0, falls = 0, lowCount = 0, frameBytes = 0;
            logic pa0 = 0, pa1 = 0, pg = 0, seenFrame = 0;
            doReset("rr");
            req0 = 1; req1 = 1;
            for (int c = 0; c < 2000 && falls < 4; c++) begin
                tick();
                if (ack0 && !pa0) grants.push_back(0);
                if (ack1 && !pa1) grants.push_back(1);
                if (gtx && !pg) begin
                    if (seenFrame)
                        checkOutput("rr gap >= 14", 32'(lowCount >= 14), 1);
                    frameBytes = 0;
                end
                if (!gtx && pg) begin
                    checkOutput("rr frame length", 32'(frameBytes), 64);
                    falls++;
                    seenFrame = 1;
                    lowCount = 0;
                end
                if (gtx) frameBytes++;
                else lowCount++;
                pa0 = ack0; pa1 = ack1; pg = gtx;
                if (ack0 && sent0 < 64) begin txen0 = 1; txd0 = 8'(sent0); sent0++; end
                else txen0 = 0;
                if (!ack0) sent0 = 0;
                if (ack1 && sent1 < 64) begin txen1 = 1; txd1 = 8'(sent1); sent1++; end
                else txen1 = 0;
                if (!ack1) sent1 = 0;
            end
            checkOutput("rr frames completed", 32'(falls), 4);
            checkOutput("rr grant count", 32'(grants.size() >= 4), 1);
            if (grants.size() >= 4) begin
                checkOutput("rr grant0", 32'(grants[0]), 0);
                checkOutput("rr grant1", 32'(grants[1]), 1);
                checkOutput("rr grant2", 32'(grants[2]), 0);
                checkOutput("rr grant3", 32'(grants[3]), 1);
            end
            req0 = 0; req1 = 0; txen0 = 0; txen1 = 0;
        end

        // Source 1 granted but never starts; source 0 waits behind it
        begin
            int ack1Count = 0, abortCount = 0, fallAt = -1, ack0At = -1;
            logic pa1 = 0;
            doReset("timeout");
            req1 = 1;
            for (int c = 0; c < 300 && ack0At < 0; c++) begin
                tick();
                if (ack1) begin ack1Count++; req0 = 1; end
                if (abort) abortCount++;
                if (pa1 && !ack1) begin
                    fallAt = c;
                    checkOutput("timeout abort at ack fall", 32'(abort), 1);
                end
                if (ack0) ack0At = c;
                pa1 = ack1;
            end
            checkOutput("timeout ack1 cycles", 32'(ack1Count), 64);
            checkOutput("timeout abort pulses", 32'(abortCount), 1);
            checkOutput("timeout req0 granted", 32'(ack0At >= 0), 1);
            checkOutput("timeout regrant delay", 32'(ack0At - fallAt), 13);
            req0 = 0; req1 = 0;
        end

        // Source 0 holds tx_en for 2000 cycles against a 1530-byte limit
        begin
            int bytes = 0, abortCount = 0, dataBad = 0, zeroBad = 0;
            logic pg = 0;
            doReset("trunc");
            req0 = 1;
            tick();
            req0 = 0;
            for (int i = 0; i < 2030; i++) begin
                txen0 = (i < 2000); txd0 = 8'(i);
                tick();
                if (gtx) begin
                    if (gtxd !== 8'(bytes)) dataBad++;
                    bytes++;
                end else if (gtxd !== 8'h00) zeroBad++;
                if (abort) begin
                    abortCount++;
                    checkOutput("trunc abort with tx_en fall", 32'(pg && !gtx && !ack0), 1);
                end
                pg = gtx;
            end
            checkOutput("trunc byte count", 32'(bytes), 1530);
            checkOutput("trunc abort pulses", 32'(abortCount), 1);
            checkOutput("trunc data errors", 32'(dataBad), 0);
            checkOutput("trunc txd nonzero while idle", 32'(zeroBad), 0);
            txen0 = 0;
        end

        // Asynchronous reset in the middle of a frame from source 0
        begin
            doReset("rstmid");
            req0 = 1;
            tick();
            for (int i = 0; i < 10; i++) begin
                txen0 = 1; txd0 = 8'(8'h5A + i);
                tick();
            end
            checkOutput("rstmid sending before reset", 32'(gtx), 1);
            #2 rst_n = 1'b0;
            #1;
            checkOutput("rstmid ack0", 32'(ack0), 0);
            checkOutput("rstmid gmii_tx_en", 32'(gtx), 0);
            checkOutput("rstmid gmii_txd", 32'(gtxd), 0);
            checkOutput("rstmid frame_abort", 32'(abort), 0);
            tick();
            txen0 = 0; req0 = 1; req1 = 1;
            rst_n = 1'b1;
            tick();
            checkOutput("rstmid first grant ack0", 32'(ack0), 1);
            checkOutput("rstmid first grant ack1", 32'(ack1), 0);
            req0 = 0; req1 = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
